// File: rtl/traffic_light_controller_param.sv
// Two-road traffic light controller with parametrised phase lengths, latched pedestrian
// request, all-red clearance and night-mode flashing entered only from highway green.
//   state  | meaning
//   S_HW_G | highway green, local red; waits for min-green and demand
//   S_HW_Y | highway yellow
//   S_RED1 | all-red clearance before local green
//   S_LR_G | local green, pedestrian walk
//   S_LR_Y | local yellow
//   S_RED2 | all-red clearance before highway green
//   S_FLSH | night flashing (highway amber / local red blink)
module traffic_light_controller_param #(
    parameter int HW_GREEN_MIN = 35,
    parameter int LR_GREEN     = 35,
    parameter int YELLOW       = 15,
    parameter int ALL_RED      = 1,
    parameter int FLASH_HALF   = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lr_has_car,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] hw_light,
    output logic [2:0] lr_light,
    output logic       ped_walk
);

    typedef enum logic [2:0] {
        S_HW_G = 3'd0,
        S_HW_Y = 3'd1,
        S_RED1 = 3'd2,
        S_LR_G = 3'd3,
        S_LR_Y = 3'd4,
        S_RED2 = 3'd5,
        S_FLSH = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] HGM_TC = CNT_W'(HW_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LRG_TC = CNT_W'(LR_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_TC = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] RED_TC = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] FLH_TC = CNT_W'(FLASH_HALF - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_ped_pending;
    logic             w_ped_next;
    logic             r_flash_ph;
    logic             w_flash_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_HW_G;
            r_count       <= '0;
            r_ped_pending <= 1'b0;
            r_flash_ph    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_count       <= w_count_next;
            r_ped_pending <= w_ped_next;
            r_flash_ph    <= w_flash_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HW_G: begin
                if (night_mode)
                    w_next = S_FLSH;
                else if ((r_count >= HGM_TC) && (lr_has_car || r_ped_pending))
                    w_next = S_HW_Y;
            end
            S_HW_Y: if (r_count == YEL_TC) w_next = S_RED1;
            S_RED1: if (r_count == RED_TC) w_next = S_LR_G;
            S_LR_G: if (r_count == LRG_TC) w_next = S_LR_Y;
            S_LR_Y: if (r_count == YEL_TC) w_next = S_RED2;
            S_RED2: if (r_count == RED_TC) w_next = S_HW_G;
            S_FLSH: if (!night_mode) w_next = S_RED2;
            default: w_next = S_HW_G;
        endcase
    end

    // HW_G count saturates so the demand check stays satisfied indefinitely.
    always_comb begin
        w_count_next = r_count + 1'b1;
        w_flash_next = r_flash_ph;
        if (w_next != r_state) begin
            w_count_next = '0;
            if (w_next == S_FLSH)
                w_flash_next = 1'b0;
        end else if ((r_state == S_HW_G) && (r_count >= HGM_TC)) begin
            w_count_next = r_count;
        end else if ((r_state == S_FLSH) && (r_count == FLH_TC)) begin
            w_count_next = '0;
            w_flash_next = ~r_flash_ph;
        end
        w_ped_next = (r_ped_pending | ped_req) & ~((w_next == S_LR_G) && (r_state != S_LR_G));
    end

    always_comb begin
        hw_light = 3'b001;
        lr_light = 3'b001;
        ped_walk = 1'b0;
        case (r_state)
            S_HW_G: hw_light = 3'b100;
            S_HW_Y: hw_light = 3'b010;
            S_LR_G: begin
                lr_light = 3'b100;
                ped_walk = 1'b1;
            end
            S_LR_Y: lr_light = 3'b010;
            S_FLSH: begin
                hw_light = r_flash_ph ? 3'b000 : 3'b010;
                lr_light = r_flash_ph ? 3'b000 : 3'b001;
            end
            default: begin
                hw_light = 3'b001;
                lr_light = 3'b001;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Scoreboard bench: default and overridden controllers share stimulus; a phase/elapsed-time
// reference model queues expected lamps per cycle and a negedge monitor checks them.
module tb_traffic_light_controller_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lr_has_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] hw0, lr0, hw1, lr1;
    logic       w0, w1;

    always #5 clk = ~clk;

    traffic_light_controller_param u_def (
        .clk(clk), .rst_n(rst_n), .lr_has_car(lr_has_car), .ped_req(ped_req),
        .night_mode(night_mode), .hw_light(hw0), .lr_light(lr0), .ped_walk(w0)
    );

    traffic_light_controller_param #(
        .HW_GREEN_MIN(4), .LR_GREEN(5), .YELLOW(3), .ALL_RED(2), .FLASH_HALF(3), .CNT_W(8)
    ) u_ovr (
        .clk(clk), .rst_n(rst_n), .lr_has_car(lr_has_car), .ped_req(ped_req),
        .night_mode(night_mode), .hw_light(hw1), .lr_light(lr1), .ped_walk(w1)
    );

    typedef struct {
        int       cyc;
        int       id;
        logic [2:0] hw;
        logic [2:0] lr;
        logic     walk;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc_cnt = 0;
    int   errors = 0;
    int   checks = 0;

    // phase 0..5 = HW_G,HW_Y,RED1,LR_G,LR_Y,RED2 ; 6 = flashing
    int dur[2][6] = '{'{35, 15, 1, 35, 15, 1}, '{4, 3, 2, 5, 3, 2}};
    int fh[2] = '{8, 3};
    int ph[2] = '{0, 0};
    int el[2] = '{0, 0};
    bit pend[2] = '{0, 0};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic model_step(input int id, input bit car, input bit ped, input bit night, input bit rstn);
        int nxt;
        if (!rstn) begin
            ph[id] = 0; el[id] = 0; pend[id] = 0;
            return;
        end
        if (ph[id] == 6)
            nxt = night ? 6 : 5;
        else if (ph[id] == 0) begin
            if (night) nxt = 6;
            else if (el[id] >= dur[id][0] - 1 && (car || pend[id])) nxt = 1;
            else nxt = 0;
        end else
            nxt = (el[id] == dur[id][ph[id]] - 1) ? (ph[id] + 1) % 6 : ph[id];
        pend[id] = (pend[id] | ped) && !(nxt == 3 && ph[id] != 3);
        el[id] = (nxt == ph[id]) ? el[id] + 1 : 0;
        ph[id] = nxt;
    endtask

    task automatic push_exp(input int id);
        exp_t x;
        bit   dark;
        x.cyc = cyc_cnt + 1;
        x.id = id;
        dark = ((el[id] / fh[id]) % 2) == 1;
        case (ph[id])
            0: begin x.hw = 3'b100; x.lr = 3'b001; end
            1: begin x.hw = 3'b010; x.lr = 3'b001; end
            3: begin x.hw = 3'b001; x.lr = 3'b100; end
            4: begin x.hw = 3'b001; x.lr = 3'b010; end
            6: begin x.hw = dark ? 3'b000 : 3'b010; x.lr = dark ? 3'b000 : 3'b001; end
            default: begin x.hw = 3'b001; x.lr = 3'b001; end
        endcase
        x.walk = (ph[id] == 3);
        q.push_back(x);
    endtask

    task automatic cyc(input bit car, input bit ped, input bit night, input bit rstn);
        @(posedge clk);
        #1;
        lr_has_car = car; ped_req = ped; night_mode = night; rst_n = rstn;
        for (int id = 0; id < 2; id++) begin
            model_step(id, car, ped, night, rstn);
            push_exp(id);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            logic [6:0] act;
            e = q.pop_front();
            checks++;
            act = (e.id == 0) ? {hw0, lr0, w0} : {hw1, lr1, w1};
            if (e.cyc != cyc_cnt) begin
                errors++;
                $display("FAIL stale dut%0d tag=%0d now=%0d", e.id, e.cyc, cyc_cnt);
            end else if (act !== {e.hw, e.lr, e.walk}) begin
                errors++;
                $display("FAIL lamps dut%0d cyc=%0d got hw=%b lr=%b walk=%b exp hw=%b lr=%b walk=%b",
                         e.id, cyc_cnt, act[6:4], act[3:1], act[0], e.hw, e.lr, e.walk);
            end
        end
    end

    task automatic bound_fail(input string name);
        errors++;
        checks++;
        $display("FAIL wait_%s not reached within budget", name);
    endtask

    initial begin
        bit night_r;
        bit hit;
        repeat (3) cyc(0, 0, 0, 0);

        // demand held from reset
        repeat (210) cyc(1, 0, 0, 1);

        // pedestrian-only cycle after long idle
        cyc(0, 0, 0, 0);
        repeat (100) cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        repeat (250) cyc(0, 0, 0, 1);

        // ped at LR_G entry edge (served) and mid LR_G (pending for next round)
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit p;
            p = (ph[0] == 2 && el[0] == dur[0][2] - 1) || (ph[0] == 3 && el[0] == 10 && i < 150);
            cyc(i < 40, p, 0, 1);
        end

        // night raised in HW_G at cycle 10
        cyc(0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 1);
        repeat (40) cyc(0, 0, 1, 1);
        repeat (50) cyc(0, 0, 0, 1);

        // night raised during LR_Y
        cyc(0, 0, 0, 0);
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cyc(1, 0, 0, 1);
            hit = (ph[0] == 4);
        end
        if (!hit) bound_fail("lr_y");
        repeat (60) cyc(0, 0, 1, 1);
        repeat (30) cyc(0, 0, 0, 1);

        // reset mid LR_G
        cyc(0, 0, 0, 0);
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cyc(1, 0, 0, 1);
            hit = (ph[0] == 3 && el[0] > 5);
        end
        if (!hit) bound_fail("lr_g");
        cyc(1, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 1);

        // randomized traffic
        night_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) night_r = ~night_r;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, night_r,
                $urandom_range(0, 499) != 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain leftover=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
